pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the pipelined processor. It produces the enable and flush controls for the PC and for the IF/ID, ID/EX and EX/MEM latches. Three conditions drive it:
- load-use hazards, detected in ID against EX;
- taken-branch/jump redirects, resolved in EX;
- multi-cycle data-memory accesses, via a req/ready handshake in MEM.
It also keeps a stall-cycle counter and raises a sticky memory-timeout halt.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/load_use_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer, its latches and the decoder.
package pipe_ctrl_pkg;

    localparam int REG_NO_WIDTH_DEF = 4;
    localparam int WAIT_CNT_WIDTH   = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // One bit per latch control, in pipeline order.
    typedef struct packed {
        logic pc_en;
        logic if_en;
        logic if_flush;
        logic id_en;
        logic id_flush;
        logic ex_en;
        logic ex_flush;
    } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still sitting in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_NO_WIDTH = REG_NO_WIDTH_DEF
) (
    input  logic [REG_NO_WIDTH-1:0] id_rs1_no,
    input  logic [REG_NO_WIDTH-1:0] id_rs2_no,
    input  logic                    id_uses_rs1,
    input  logic                    id_uses_rs2,
    input  logic [REG_NO_WIDTH-1:0] ex_reg_write_no,
    input  logic                    ex_wr_reg,
    input  logic                    ex_is_load,
    output logic                    load_use
);

    // Register 0 is compared like any other register.
    assign load_use = ex_is_load & ex_wr_reg &
                      ((id_uses_rs1 & (id_rs1_no == ex_reg_write_no)) |
                       (id_uses_rs2 & (id_rs2_no == ex_reg_write_no)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch squashes, memory freezes and a sticky timeout halt.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_NO_WIDTH    = REG_NO_WIDTH_DEF,
    parameter int MEM_WAIT_MAX    = 15,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [REG_NO_WIDTH-1:0]    idRs1No,
    input  logic [REG_NO_WIDTH-1:0]    idRs2No,
    input  logic                       idUsesRs1,
    input  logic                       idUsesRs2,
    input  logic [REG_NO_WIDTH-1:0]    exRegWriteNo,
    input  logic                       exWrReg,
    input  logic                       exIsLoad,
    input  logic                       memReq,
    input  logic                       memReady,
    input  logic                       branchRedirect,
    output logic                       pcWriteEn,
    output logic                       ifLatchEn,
    output logic                       ifLatchFlush,
    output logic                       idLatchEn,
    output logic                       idLatchFlush,
    output logic                       exLatchEn,
    output logic                       exLatchFlush,
    output logic [STALL_CNT_WIDTH-1:0] stallCycles,
    output logic                       memTimeout,
    output logic [1:0]                 dbg_state,
    output logic [WAIT_CNT_WIDTH-1:0]  dbg_wait_cnt
);

    state_t                    state;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
    logic                      load_use;
    logic                      mem_stall;
    ctrl_t                     ctrl;

    load_use_detect #(.REG_NO_WIDTH(REG_NO_WIDTH)) u_load_use (
        .id_rs1_no       (idRs1No),
        .id_rs2_no       (idRs2No),
        .id_uses_rs1     (idUsesRs1),
        .id_uses_rs2     (idUsesRs2),
        .ex_reg_write_no (exRegWriteNo),
        .ex_wr_reg       (exWrReg),
        .ex_is_load      (exIsLoad),
        .load_use        (load_use)
    );

    assign mem_stall = memReq & ~memReady;

    // A redirect seen during a freeze stays asserted because EX is frozen,
    // so it naturally takes effect in the release cycle.
    always_comb begin
        ctrl = '0;
        if (!reset) begin
            ctrl.if_flush = 1'b1;
            ctrl.id_flush = 1'b1;
            ctrl.ex_flush = 1'b1;
        end else if (state == HALT || mem_stall) begin
            ctrl = '0;
        end else if (branchRedirect) begin
            ctrl.pc_en    = 1'b1;
            ctrl.if_flush = 1'b1;
            ctrl.id_flush = 1'b1;
            ctrl.ex_en    = 1'b1;
        end else if (load_use) begin
            ctrl.id_flush = 1'b1;
            ctrl.ex_en    = 1'b1;
        end else begin
            ctrl.pc_en = 1'b1;
            ctrl.if_en = 1'b1;
            ctrl.id_en = 1'b1;
            ctrl.ex_en = 1'b1;
        end
    end

    assign pcWriteEn    = ctrl.pc_en;
    assign ifLatchEn    = ctrl.if_en;
    assign ifLatchFlush = ctrl.if_flush;
    assign idLatchEn    = ctrl.id_en;
    assign idLatchFlush = ctrl.id_flush;
    assign exLatchEn    = ctrl.ex_en;
    assign exLatchFlush = ctrl.ex_flush;
    assign dbg_state    = state;
    assign dbg_wait_cnt = wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stallCycles <= '0;
            memTimeout  <= 1'b0;
        end else begin
            if (!ctrl.pc_en && stallCycles != '1)
                stallCycles <= stallCycles + STALL_CNT_WIDTH'(1);
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_CNT_WIDTH'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_CNT_WIDTH'(MEM_WAIT_MAX)) begin
                        state      <= HALT;
                        memTimeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_WIDTH'(1);
                    end
                end
                HALT: state <= HALT;
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a scoreboard of expected control/state snapshots.
module tb_pipeline_hazard_ctrl;

    localparam int RW = 4;
    localparam int SW = 16;
    localparam int CW = 8;
    localparam int XW = 7 + 2 + CW + 1 + SW;

    // {pc_en, if_en, if_flush, id_en, id_flush, ex_en, ex_flush}
    localparam logic [6:0] C_RESET  = 7'b0010101;
    localparam logic [6:0] C_RUN    = 7'b1101010;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_REDIR  = 7'b1010110;
    localparam logic [6:0] C_LU     = 7'b0000110;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] idRs1No, idRs2No, exRegWriteNo;
    logic          idUsesRs1, idUsesRs2, exWrReg, exIsLoad;
    logic          memReq, memReady, branchRedirect;
    logic          pcWriteEn, ifLatchEn, ifLatchFlush, idLatchEn, idLatchFlush;
    logic          exLatchEn, exLatchFlush, memTimeout;
    logic [SW-1:0] stallCycles;
    logic [1:0]    dbg_state;
    logic [CW-1:0] dbg_wait_cnt;

    logic [XW-1:0] exp_q[$];
    int            total_cnt = 0;
    int            pass_cnt  = 0;
    int            stall_model = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_NO_WIDTH(RW), .MEM_WAIT_MAX(15), .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk(clk), .reset(reset),
        .idRs1No(idRs1No), .idRs2No(idRs2No),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
        .exRegWriteNo(exRegWriteNo), .exWrReg(exWrReg), .exIsLoad(exIsLoad),
        .memReq(memReq), .memReady(memReady), .branchRedirect(branchRedirect),
        .pcWriteEn(pcWriteEn), .ifLatchEn(ifLatchEn), .ifLatchFlush(ifLatchFlush),
        .idLatchEn(idLatchEn), .idLatchFlush(idLatchFlush),
        .exLatchEn(exLatchEn), .exLatchFlush(exLatchFlush),
        .stallCycles(stallCycles), .memTimeout(memTimeout),
        .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
    );

    task automatic clear_inputs();
        idRs1No = '0; idRs2No = '0; exRegWriteNo = '0;
        idUsesRs1 = 0; idUsesRs2 = 0; exWrReg = 0; exIsLoad = 0;
        memReq = 0; memReady = 0; branchRedirect = 0;
    endtask

    task automatic set_load_use(input logic [RW-1:0] rs1, input logic u1,
                                input logic [RW-1:0] rs2, input logic u2,
                                input logic [RW-1:0] dst, input logic wr, input logic ld);
        idRs1No = rs1; idUsesRs1 = u1; idRs2No = rs2; idUsesRs2 = u2;
        exRegWriteNo = dst; exWrReg = wr; exIsLoad = ld;
    endtask

    // Compare the current DUT snapshot against the expectation pushed for it.
    task automatic expect_now(input string tag, input logic [6:0] c, input logic [1:0] st,
                              input int cnt, input logic to);
        logic [XW-1:0] obs;
        logic [XW-1:0] exp;
        exp_q.push_back({c, st, CW'(cnt), to, SW'(stall_model)});
        obs = {pcWriteEn, ifLatchEn, ifLatchFlush, idLatchEn, idLatchFlush,
               exLatchEn, exLatchFlush, dbg_state, dbg_wait_cnt, memTimeout, stallCycles};
        exp = exp_q.pop_front();
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Inputs already driven; check mid-cycle, then advance past the next rising edge.
    task automatic step(input string tag, input logic [6:0] c, input logic [1:0] st,
                        input int cnt, input logic to);
        @(negedge clk);
        expect_now(tag, c, st, cnt, to);
        @(posedge clk);
        if (reset && !c[6]) stall_model++;
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        step("reset_hold", C_RESET, S_RUN, 0, 0);
        reset = 1'b1;
        step("idle", C_RUN, S_RUN, 0, 0);

        // Load-use on rs1, then the bubble clears it.
        set_load_use(4'd3, 1, 4'd4, 1, 4'd3, 1, 1);
        step("lu_rs1", C_LU, S_RUN, 0, 0);
        set_load_use(4'd3, 1, 4'd4, 1, 4'd0, 0, 0);
        step("lu_bubble", C_RUN, S_RUN, 0, 0);
        set_load_use(4'd7, 0, 4'd0, 1, 4'd0, 1, 1);
        step("lu_rs2_r0", C_LU, S_RUN, 0, 0);
        set_load_use(4'd3, 0, 4'd3, 0, 4'd3, 1, 1);
        step("no_lu_unused", C_RUN, S_RUN, 0, 0);
        set_load_use(4'd3, 1, 4'd0, 0, 4'd3, 0, 1);
        step("no_lu_nowr", C_RUN, S_RUN, 0, 0);
        set_load_use(4'd3, 1, 4'd0, 0, 4'd3, 1, 0);
        step("no_lu_notload", C_RUN, S_RUN, 0, 0);
        for (int i = 0; i < 3; i++) begin
            set_load_use(RW'($urandom_range(0, 15)), 1, RW'($urandom_range(0, 15)), 1,
                         RW'($urandom_range(0, 15)), 1, 1);
            idRs1No = exRegWriteNo;
            step("lu_rand", C_LU, S_RUN, 0, 0);
        end
        clear_inputs();

        // Redirect alone, then redirect racing a load-use.
        branchRedirect = 1;
        step("redirect", C_REDIR, S_RUN, 0, 0);
        branchRedirect = 0;
        step("post_redirect", C_RUN, S_RUN, 0, 0);
        set_load_use(4'd5, 1, 4'd0, 0, 4'd5, 1, 1);
        branchRedirect = 1;
        step("redir_over_lu", C_REDIR, S_RUN, 0, 0);
        clear_inputs();

        // Four-cycle memory freeze.
        memReq = 1;
        step("mem_f0", C_FREEZE, S_RUN, 0, 0);
        for (int i = 1; i < 4; i++) step("mem_fw", C_FREEZE, S_WAIT, i, 0);
        memReady = 1;
        step("mem_release", C_RUN, S_WAIT, 4, 0);
        memReq = 0; memReady = 0;
        step("mem_back_run", C_RUN, S_RUN, 0, 0);

        // Back-to-back accesses restart the wait counter.
        memReq = 1;
        step("b2b_f0", C_FREEZE, S_RUN, 0, 0);
        memReady = 1;
        step("b2b_rel", C_RUN, S_WAIT, 1, 0);
        memReady = 0;
        step("b2b_f1", C_FREEZE, S_RUN, 0, 0);
        memReady = 1;
        step("b2b_rel2", C_RUN, S_WAIT, 1, 0);
        clear_inputs();

        // Redirect held across a three-cycle freeze.
        memReq = 1; branchRedirect = 1;
        step("rf_f0", C_FREEZE, S_RUN, 0, 0);
        step("rf_f1", C_FREEZE, S_WAIT, 1, 0);
        step("rf_f2", C_FREEZE, S_WAIT, 2, 0);
        memReady = 1;
        step("rf_release", C_REDIR, S_WAIT, 3, 0);
        clear_inputs();
        step("rf_after", C_RUN, S_RUN, 0, 0);

        // Asynchronous reset in the middle of a wait.
        memReq = 1;
        step("ar_f0", C_FREEZE, S_RUN, 0, 0);
        step("ar_f1", C_FREEZE, S_WAIT, 1, 0);
        #2;
        reset = 1'b0;
        stall_model = 0;
        #1;
        expect_now("async_reset", C_RESET, S_RUN, 0, 0);
        clear_inputs();
        @(posedge clk); #1;
        reset = 1'b1;
        step("ar_after", C_RUN, S_RUN, 0, 0);

        // Memory never answers: 16 frozen cycles, then sticky halt.
        memReq = 1;
        step("to_f0", C_FREEZE, S_RUN, 0, 0);
        for (int i = 1; i < 16; i++) step("to_fw", C_FREEZE, S_WAIT, i, 0);
        step("to_halt", C_FREEZE, S_HALT, 15, 1);
        memReady = 1; branchRedirect = 1;
        step("halt_sticky", C_FREEZE, S_HALT, 15, 1);
        clear_inputs();
        step("halt_idle", C_FREEZE, S_HALT, 15, 1);
        #3;
        reset = 1'b0;
        stall_model = 0;
        #1;
        expect_now("halt_reset", C_RESET, S_RUN, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        step("halt_cleared", C_RUN, S_RUN, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
